m6809_cpld_glue: RTL and testbench
==================================

# m6809_cpld_glue

Programmable bus-glue logic for the 6809 CPU card's XC9572 CPLD. It sits between the MC6809 (E, Q, BA, BS, RnW, address) and the 50-way system connector. It re-times E and Q into the HSCLK domain and generates the registered chip selects, interrupt-acknowledge and bus-grant acknowledge. It also generates a stretched, debounced CPU reset and a DIP-selectable auxiliary clock. All logic runs from the CMOS oscillator clock HSCLK, which is 4× the E frequency.

## Interface

Parameters:
- IO_PAGE, 8'hFC: value of A[15:8] that selects the I/O page.
- RST_HOLD, 16: number of E cycles CPU_RST_B stays low after every reset source has released; range 1–255.

Ports:
- HSCLK  in  1  CPLD global clock (GCK1).
- RST  in  1  asynchronous, active-high reset.
- ECLK_LPF  in  1  filtered 6809 E; asynchronous to HSCLK.
- QCLK  in  1  6809 Q; asynchronous to HSCLK.
- BA, BS  in  1 each  6809 bus status.
- RNW  in  1  6809 read/not-write; sampled only, no function in v1.
- A  in  8  CPU address bits A[15:8].
- A7  in  1  CPU address bit 7.
- SW_RST_B  in  1  reset push-button, active low, RC-filtered.
- DIP  in  2  option switches, active low.
- SYS_ECLK  out  1  re-timed E to the system bus.
- SYS_Q_AUXCLK  out  1  Q or divided HSCLK, selected by DIP.
- SYS_A8  out  1  remapped A8 (combinational).
- CSUART_B, CSIO_B  out  1 each  I/O chip selects, active low.
- IACK_B  out  1  interrupt-vector acknowledge, active low.
- BUSACK_B  out  1  bus-grant acknowledge, active low.
- CPU_RST_B  out  1  reset to the CPU and system bus, active low.

## Operation

- **Synchronisers.** ECLK_LPF, QCLK, SW_RST_B and DIP each pass through a 2-flop synchroniser.
  - Ef = falling edge of synchronised E. Qr = rising edge of synchronised Q.
  - Edges are detected with one further register stage.
- **SYS_ECLK.** Equals synchronised E. It is delayed 2 HSCLK cycles from the pin.
- **SYS_A8.** Equals A[8] XOR (BS & ~BA). This is the only purely combinational output.
- **Decode.**
  - page = (A[15:8] == IO_PAGE) & ~BA.
  - uart = page & ~A7.
  - io = page & A7.
- **Chip selects.**
  - On Qr, CSUART_B loads ~uart and CSIO_B loads ~io.
  - On Ef, both go to 1.
  - If Qr and Ef occur in the same cycle, Ef wins.
  - At most one chip select is low at any time.
- **IACK_B.** On Qr, loads ~(BS & ~BA). On Ef, goes to 1. This marks the vector fetch.
- **BUSACK_B.** Driven by a 2-bit grant counter, advanced only on Ef.
  - BS & BA sampled true: counter saturates up.
  - Otherwise: counter clears.
  - BUSACK_B = 0 while counter == 2. It therefore needs two consecutive granted E cycles and releases on the first non-granted Ef.
- **Reset FSM.** States HOLD and RUN.
  - RST forces HOLD and loads count = RST_HOLD.
  - In HOLD, while synchronised SW_RST_B == 0, count reloads RST_HOLD.
  - In HOLD, otherwise, count decrements on each Ef. Moving to RUN happens on the Ef where count goes 1→0.
  - In RUN, synchronised SW_RST_B == 0 moves to HOLD and reloads the count.
  - CPU_RST_B = 0 in HOLD and 1 in RUN. It is registered.
- **Aux clock.** A free-running 3-bit counter cnt increments every HSCLK cycle. DIP selection (synchronised, inverted), with the mux output registered:
  - 00: synchronised Q.
  - 01: cnt[0] (HSCLK/2).
  - 10: cnt[1] (HSCLK/4).
  - 11: cnt[2] (HSCLK/8).
  - The selection register updates only on the cycle cnt == 7, so switching is glitch-free.
  - cnt wraps from 7 to 0.

## Timing

- Reset values:
  - SYS_ECLK = 0, SYS_Q_AUXCLK = 0.
  - CSUART_B = CSIO_B = IACK_B = BUSACK_B = 1.
  - CPU_RST_B = 0.
  - FSM = HOLD, count = RST_HOLD, cnt = 0, selection = 00.
- Latency from pin edge to register update:
  - Qr and Ef edges act 3 HSCLK cycles after the pin edge.
  - Chip selects and IACK_B change 1 cycle after that, i.e. 4 cycles from the pin edge.
  - SYS_ECLK trails the pin by 2 cycles.
- Address and BS/BA must be stable at Qr. The 6809 guarantees this, because address is valid before Q rises.
- RST asserted mid-cycle: all outputs return to reset values immediately (asynchronously). A held chip select is released without waiting for Ef.
- No E edges while in HOLD (E stopped): CPU_RST_B remains low indefinitely.
- Counters:
  - count is 8 bits and does not underflow; it is never decremented at 0.
  - The grant counter saturates at 2.

## Test plan

- **Reset and hold.** E period = 4 HSCLK, RST pulse, RST_HOLD = 16 → all outputs at reset values; CPU_RST_B rises on the 16th Ef after RST falls. Press SW_RST_B for 3 E cycles in RUN → CPU_RST_B low, then high 16 Ef after release.
- **I/O decode.**
  - A = 8'hFC, A7 = 0, BA = 0 → CSUART_B low from Qr+1 to Ef+1; CSIO_B stays 1.
  - A = 8'hFC, A7 = 1 → CSIO_B only.
  - A = 8'hFD → neither.
- **Vector fetch.** BS = 1, BA = 0, A = 8'hFF → IACK_B low for exactly one E cycle; SYS_A8 = ~A[8] during it.
- **Bus grant.** BS = BA = 1 for 3 E cycles → BUSACK_B low after the 2nd Ef and high at the first Ef after release. A 1-cycle grant pulse → BUSACK_B stays 1.
- **Aux clock.**
  - DIP = 2'b01 (inverted selection 10) → SYS_Q_AUXCLK period 4 HSCLK.
  - DIP changed mid-count → new rate starts only after cnt == 7, with no pulse shorter than 1 HSCLK.
- **Async reset mid-transfer.** RST asserted while CSIO_B is low → CSIO_B = 1 in the same cycle, before the next HSCLK edge.

Source files
------------

// File: rtl/m6809_cpld_glue.sv
// rtl/m6809_cpld_glue.sv - 6809 CPU card bus glue: E/Q re-timing, I/O chip selects, IACK, bus grant, reset stretch, aux clock
// Everything runs on HSCLK (4x E); E, Q, the reset button and DIP switches are synchronised first.
module m6809_cpld_glue #(
   parameter logic [7:0] IO_PAGE  = 8'hFC,
   parameter int         RST_HOLD = 16
) (
   input  logic       HSCLK,
   input  logic       RST,
   input  logic       ECLK_LPF,
   input  logic       QCLK,
   input  logic       BA,
   input  logic       BS,
   input  logic       RNW,
   input  logic [7:0] A,
   input  logic       A7,
   input  logic       SW_RST_B,
   input  logic [1:0] DIP,
   output logic       SYS_ECLK,
   output logic       SYS_Q_AUXCLK,
   output logic       SYS_A8,
   output logic       CSUART_B,
   output logic       CSIO_B,
   output logic       IACK_B,
   output logic       BUSACK_B,
   output logic       CPU_RST_B
);

   typedef enum logic {HOLD = 1'b0, RUN = 1'b1} rst_state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD);

   logic       e_s1, e_s2, e_s3;
   logic       q_s1, q_s2, q_s3;
   logic       sw_s1, sw_s2;
   logic [1:0] dip_s1, dip_s2;
   logic       ef, qr;
   logic       page;
   logic [1:0] grant;
   rst_state_t state, state_nxt;
   logic [7:0] count, count_nxt;
   logic [2:0] cnt;
   logic [1:0] sel;
   logic       aux_mux;
   logic       unused_rnw;

   // RNW has no function yet; kept on the pinout for later revisions.
   assign unused_rnw = &{1'b0, RNW};

   // Inactive reset values on the button/DIP synchronisers keep a fresh reset from re-arming itself.
   always_ff @(posedge HSCLK or posedge RST) begin
      if (RST) begin
         e_s1   <= 1'b0;
         e_s2   <= 1'b0;
         e_s3   <= 1'b0;
         q_s1   <= 1'b0;
         q_s2   <= 1'b0;
         q_s3   <= 1'b0;
         sw_s1  <= 1'b1;
         sw_s2  <= 1'b1;
         dip_s1 <= 2'b11;
         dip_s2 <= 2'b11;
         ef     <= 1'b0;
         qr     <= 1'b0;
      end else begin
         e_s1   <= ECLK_LPF;
         e_s2   <= e_s1;
         e_s3   <= e_s2;
         q_s1   <= QCLK;
         q_s2   <= q_s1;
         q_s3   <= q_s2;
         sw_s1  <= SW_RST_B;
         sw_s2  <= sw_s1;
         dip_s1 <= DIP;
         dip_s2 <= dip_s1;
         ef     <= e_s3 & ~e_s2;
         qr     <= ~q_s3 & q_s2;
      end
   end

   assign SYS_ECLK = e_s2;
   assign SYS_A8   = A[0] ^ (BS & ~BA);
   assign page     = (A == IO_PAGE) & ~BA;

   // End of the E cycle always releases, even if a Q edge lands on the same clock.
   always_ff @(posedge HSCLK or posedge RST) begin
      if (RST) begin
         CSUART_B <= 1'b1;
         CSIO_B   <= 1'b1;
         IACK_B   <= 1'b1;
      end else if (ef) begin
         CSUART_B <= 1'b1;
         CSIO_B   <= 1'b1;
         IACK_B   <= 1'b1;
      end else if (qr) begin
         CSUART_B <= ~(page & ~A7);
         CSIO_B   <= ~(page & A7);
         IACK_B   <= ~(BS & ~BA);
      end
   end

   always_ff @(posedge HSCLK or posedge RST) begin
      if (RST) begin
         grant <= 2'd0;
      end else if (ef) begin
         if (BS & BA) begin
            grant <= (grant == 2'd2) ? 2'd2 : grant + 2'd1;
         end else begin
            grant <= 2'd0;
         end
      end
   end

   assign BUSACK_B = (grant != 2'd2);

   always_ff @(posedge HSCLK or posedge RST) begin
      if (RST) begin
         state <= HOLD;
         count <= HOLD_LOAD;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         HOLD: begin
            if (!sw_s2) begin
               count_nxt = HOLD_LOAD;
            end else if (ef && count != 8'd0) begin
               count_nxt = count - 8'd1;
               if (count == 8'd1) state_nxt = RUN;
            end
         end
         RUN: begin
            if (!sw_s2) begin
               state_nxt = HOLD;
               count_nxt = HOLD_LOAD;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   assign CPU_RST_B = (state == RUN);

   // Selection only changes at cnt == 7, when every divided clock is about to restart together.
   always_comb begin
      aux_mux = q_s2;
      case (sel)
         2'd1:    aux_mux = cnt[0];
         2'd2:    aux_mux = cnt[1];
         2'd3:    aux_mux = cnt[2];
         default: aux_mux = q_s2;
      endcase
   end

   always_ff @(posedge HSCLK or posedge RST) begin
      if (RST) begin
         cnt          <= 3'd0;
         sel          <= 2'd0;
         SYS_Q_AUXCLK <= 1'b0;
      end else begin
         cnt          <= cnt + 3'd1;
         SYS_Q_AUXCLK <= aux_mux;
         if (cnt == 3'd7) sel <= ~dip_s2;
      end
   end

endmodule

// File: tb/tb_m6809_cpld_glue.sv
// tb/tb_m6809_cpld_glue.sv - self-checking bench for m6809_cpld_glue
// A pin-history model predicts every output each cycle; directed bus cycles add literal expectations.
module tb_m6809_cpld_glue;

   logic       HSCLK;
   logic       RST;
   logic       ECLK_LPF, QCLK, BA, BS, RNW, A7, SW_RST_B;
   logic [7:0] A;
   logic [1:0] DIP;
   logic       SYS_ECLK, SYS_Q_AUXCLK, SYS_A8, CSUART_B, CSIO_B, IACK_B, BUSACK_B, CPU_RST_B;

   int n_checks = 0;
   int n_fail   = 0;

   m6809_cpld_glue #(.IO_PAGE(8'hFC), .RST_HOLD(16)) dut (
      .HSCLK(HSCLK), .RST(RST), .ECLK_LPF(ECLK_LPF), .QCLK(QCLK), .BA(BA), .BS(BS),
      .RNW(RNW), .A(A), .A7(A7), .SW_RST_B(SW_RST_B), .DIP(DIP),
      .SYS_ECLK(SYS_ECLK), .SYS_Q_AUXCLK(SYS_Q_AUXCLK), .SYS_A8(SYS_A8),
      .CSUART_B(CSUART_B), .CSIO_B(CSIO_B), .IACK_B(IACK_B), .BUSACK_B(BUSACK_B),
      .CPU_RST_B(CPU_RST_B)
   );

   initial HSCLK = 1'b0;
   always #5 HSCLK = ~HSCLK;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: pin values seen at the last five clock edges, index 0 = this edge.
   logic       eh[5];
   logic       qh[5];
   logic       swh[5];
   logic [1:0] diph[5];
   int m_csu = 1, m_csi = 1, m_iack = 1, m_g = 0, m_hold = 1, m_count = 16;
   int m_cnt = 0, m_sel = 0, m_aux = 0;

   task automatic m_reset();
      for (int i = 0; i < 5; i++) begin
         eh[i] = 1'b0; qh[i] = 1'b0; swh[i] = 1'b1; diph[i] = 2'b11;
      end
      m_csu = 1; m_csi = 1; m_iack = 1; m_g = 0; m_hold = 1; m_count = 16;
      m_cnt = 0; m_sel = 0; m_aux = 0;
   endtask

   always @(posedge HSCLK or posedge RST) begin
      if (RST) begin
         m_reset();
      end else begin
         bit ef, qr, page;
         for (int i = 4; i > 0; i--) begin
            eh[i] = eh[i-1]; qh[i] = qh[i-1]; swh[i] = swh[i-1]; diph[i] = diph[i-1];
         end
         eh[0] = ECLK_LPF; qh[0] = QCLK; swh[0] = SW_RST_B; diph[0] = DIP;
         // A pin edge takes effect on the fourth clock edge that sees it.
         ef   = eh[4] && !eh[3];
         qr   = !qh[4] && qh[3];
         page = (A == 8'hFC) && !BA;
         if (ef) begin
            m_csu = 1; m_csi = 1; m_iack = 1;
            m_g = (BS && BA) ? ((m_g < 2) ? m_g + 1 : 2) : 0;
         end else if (qr) begin
            m_csu  = (page && !A7) ? 0 : 1;
            m_csi  = (page && A7) ? 0 : 1;
            m_iack = (BS && !BA) ? 0 : 1;
         end
         m_aux = (m_sel == 0) ? int'(qh[2]) : ((m_cnt >> (m_sel - 1)) & 1);
         if (m_cnt == 7) m_sel = 3 - int'(diph[2]);
         m_cnt = (m_cnt + 1) % 8;
         if (m_hold != 0) begin
            if (!swh[2]) m_count = 16;
            else if (ef && m_count > 0) begin
               m_count--;
               if (m_count == 0) m_hold = 0;
            end
         end else if (!swh[2]) begin
            m_hold = 1; m_count = 16;
         end
      end
   end

   int   lo_csu, lo_csi, lo_iack, lo_iack_a8, lo_bus, aux_hi, aux_rise;
   logic aux_prev = 1'b0;

   always @(posedge HSCLK) begin
      #1;
      check("sys_eclk", SYS_ECLK, eh[1]);
      check("sys_a8", SYS_A8, A[0] ^ (BS & ~BA));
      check("csuart_b", CSUART_B, m_csu);
      check("csio_b", CSIO_B, m_csi);
      check("iack_b", IACK_B, m_iack);
      check("busack_b", BUSACK_B, (m_g == 2) ? 0 : 1);
      check("cpu_rst_b", CPU_RST_B, (m_hold != 0) ? 0 : 1);
      check("sys_q_auxclk", SYS_Q_AUXCLK, m_aux);
      check("cs_exclusive", CSUART_B | CSIO_B, 1);
      if (!CSUART_B) lo_csu++;
      if (!CSIO_B) lo_csi++;
      if (!IACK_B) lo_iack++;
      if (!IACK_B && !SYS_A8) lo_iack_a8++;
      if (!BUSACK_B) lo_bus++;
      if (SYS_Q_AUXCLK) aux_hi++;
      if (SYS_Q_AUXCLK && !aux_prev) aux_rise++;
      aux_prev = SYS_Q_AUXCLK;
   end

   task automatic zero_counts();
      lo_csu = 0; lo_csi = 0; lo_iack = 0; lo_iack_a8 = 0; lo_bus = 0; aux_hi = 0; aux_rise = 0;
   endtask

   // One E cycle: Q rises, E rises, Q falls, E falls; bus pins change with the E fall.
   task automatic run_cycle(input logic [7:0] a, input logic a7, input logic ba, input logic bs);
      @(negedge HSCLK); ECLK_LPF = 1'b0; QCLK = 1'b0; A = a; A7 = a7; BA = ba; BS = bs;
      @(negedge HSCLK); QCLK = 1'b1;
      @(negedge HSCLK); ECLK_LPF = 1'b1;
      @(negedge HSCLK); QCLK = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) run_cycle(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic xact(input logic [7:0] a, input logic a7, input logic ba, input logic bs);
      zero_counts();
      run_cycle(a, a7, ba, bs);
      idle(2);
   endtask

   task automatic measure_release(input string nm);
      int   falls;
      logic prev;
      bit   done;
      falls = 0; prev = SYS_ECLK; done = 0;
      fork
         idle(22);
         begin
            for (int i = 0; i < 100 && !done; i++) begin
               @(posedge HSCLK); #1;
               if (prev && !SYS_ECLK) falls++;
               prev = SYS_ECLK;
               if (CPU_RST_B) done = 1;
            end
         end
      join
      check({nm, "_released"}, int'(done), 1);
      check({nm, "_ef_count"}, falls, 16);
   endtask

   initial begin
      RST = 1'b1; ECLK_LPF = 1'b0; QCLK = 1'b0; BA = 1'b0; BS = 1'b0; RNW = 1'b1;
      A = 8'h00; A7 = 1'b0; SW_RST_B = 1'b1; DIP = 2'b11;
      zero_counts();
      idle(2);
      check("rst_cpu_rst_b", CPU_RST_B, 0);
      check("rst_csuart_b", CSUART_B, 1);
      check("rst_csio_b", CSIO_B, 1);
      check("rst_iack_b", IACK_B, 1);
      check("rst_busack_b", BUSACK_B, 1);
      check("rst_sys_eclk", SYS_ECLK, 0);
      check("rst_auxclk", SYS_Q_AUXCLK, 0);
      RST = 1'b0;
      measure_release("por");

      SW_RST_B = 1'b0;
      idle(3);
      check("sw_press_cpu_rst_b", CPU_RST_B, 0);
      SW_RST_B = 1'b1;
      measure_release("sw");

      xact(8'hFC, 1'b0, 1'b0, 1'b0);
      check("uart_csuart_low", lo_csu, 3);
      check("uart_csio_low", lo_csi, 0);
      xact(8'hFC, 1'b1, 1'b0, 1'b0);
      check("io_csuart_low", lo_csu, 0);
      check("io_csio_low", lo_csi, 3);
      xact(8'hFD, 1'b0, 1'b0, 1'b0);
      check("fd_cs_low", lo_csu + lo_csi, 0);
      xact(8'hFC, 1'b0, 1'b1, 1'b0);
      check("ba_blocks_cs", lo_csu + lo_csi, 0);
      xact(8'hFF, 1'b1, 1'b0, 1'b1);
      check("vec_iack_low", lo_iack, 3);
      check("vec_a8_inverted", lo_iack_a8, 3);
      check("vec_cs_low", lo_csu + lo_csi, 0);

      zero_counts();
      repeat (3) run_cycle(8'h00, 1'b0, 1'b1, 1'b1);
      idle(2);
      check("grant3_busack_low", lo_bus, 8);
      check("grant3_no_iack", lo_iack, 0);
      zero_counts();
      run_cycle(8'h00, 1'b0, 1'b1, 1'b1);
      idle(2);
      check("grant1_busack_low", lo_bus, 0);

      DIP = 2'b01;
      idle(6);
      zero_counts();
      idle(4);
      check("div4_high", aux_hi, 8);
      check("div4_rises", aux_rise, 4);
      @(negedge HSCLK); @(negedge HSCLK); @(negedge HSCLK);
      DIP = 2'b00;
      idle(6);
      zero_counts();
      idle(4);
      check("div8_high", aux_hi, 8);
      check("div8_rises", aux_rise, 2);
      @(negedge HSCLK);
      DIP = 2'b10;
      idle(6);
      zero_counts();
      idle(4);
      check("div2_rises", aux_rise, 8);
      DIP = 2'b11;
      idle(6);

      begin
         bit found;
         found = 0;
         fork
            begin
               run_cycle(8'hFC, 1'b1, 1'b0, 1'b0);
               idle(2);
            end
            begin
               repeat (16) begin
                  @(posedge HSCLK); #1;
                  if (!found && !CSIO_B) begin
                     found = 1;
                     #2;
                     RST = 1'b1;
                     #1;
                     check("async_csio_b", CSIO_B, 1);
                     check("async_cpu_rst_b", CPU_RST_B, 0);
                     check("async_auxclk", SYS_Q_AUXCLK, 0);
                  end
               end
            end
         join
         check("async_csio_seen_low", int'(found), 1);
      end
      RST = 1'b0;
      measure_release("post_async");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
